// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction fetch queue.
// The package covers the fetch state, the redirect kinds and the redirect priority decode.
package ifetch_pkg;

   localparam int XLEN_DEFAULT = 32;
   localparam int INST_BYTES   = 4;

   typedef enum logic {
      RUN,
      FAULT
   } fetch_state_t;

   typedef enum logic [1:0] {
      REDIR_NONE,
      REDIR_BRANCH,
      REDIR_JAL,
      REDIR_JALR
   } redir_kind_t;

   // jalr wins over jal, and jal wins over a taken branch.
   function automatic redir_kind_t redir_decode(input logic branch, input logic jal,
                                                input logic jalr);
      if (jalr)
         return REDIR_JALR;
      if (jal)
         return REDIR_JAL;
      if (branch)
         return REDIR_BRANCH;
      return REDIR_NONE;
   endfunction

endpackage

// File: rtl/ifetch_queue_fifo.sv
// Synchronous FIFO with occupancy count and a single-cycle flush.
// Flush overrides a push or pop in the same cycle.
module sync_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     flush,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         pop_data,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [CW-1:0]    cnt;
   logic             full;
   logic             empty;
   logic             do_push;
   logic             do_pop;

   assign full     = (cnt == CW'(DEPTH));
   assign empty    = (cnt == '0);
   assign do_pop   = pop && !empty;
   assign do_push  = push && (!full || do_pop);
   assign pop_data = mem[rd_ptr];
   assign count    = cnt;

   always_ff @(posedge clk) begin
      if (!rst_n || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (do_pop)
            rd_ptr <= rd_ptr + AW'(1);
         cnt <= cnt + CW'(do_push) - CW'(do_pop);
      end
   end

endmodule

// File: rtl/ifetch_queue.sv
// Fetch unit: issues word fetches under a credit limit and queues returned instructions with their PCs.
// Redirects flush queued and in-flight work; a misaligned target parks the unit in FAULT.
module ifetch_queue
   import ifetch_pkg::*;
#(
   parameter int              XLEN     = XLEN_DEFAULT,
   parameter logic [XLEN-1:0] RESET_PC = '0,
   parameter int              FQ_DEPTH = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_rsp_valid,
   input  logic [31:0]     imem_rsp_data,
   input  logic            redir_branch,
   input  logic            redir_jal,
   input  logic            redir_jalr,
   input  logic [XLEN-1:0] redir_pc,
   input  logic [XLEN-1:0] rs1,
   input  logic [XLEN-1:0] imm,
   output logic            inst_valid,
   input  logic            inst_ready,
   output logic [31:0]     inst_data,
   output logic [XLEN-1:0] inst_pc,
   output logic            fetch_fault,
   output logic [XLEN-1:0] fault_addr
);

   localparam int            CW        = $clog2(FQ_DEPTH) + 1;
   localparam logic [CW:0]   DEPTH_LIM = (CW + 1)'(FQ_DEPTH);

   fetch_state_t       state;
   fetch_state_t       state_next;
   redir_kind_t        kind;
   logic [XLEN-1:0]    fetch_pc;
   logic [XLEN-1:0]    target;
   logic               redir;
   logic               target_bad;
   logic [CW-1:0]      in_flight;
   logic [CW-1:0]      in_flight_next;
   logic [CW-1:0]      drop_cnt;
   logic [CW-1:0]      q_count;
   logic [CW-1:0]      tag_count;
   logic [CW:0]        occupancy;
   logic               req_hs;
   logic               rsp_push;
   logic               q_pop;
   logic               q_empty;
   logic [XLEN-1:0]    tag_pc;
   logic [XLEN+31:0]   q_head;
   logic [XLEN+31:0]   head_hold;

   // Redirect target: jalr clears bit 0 of rs1+imm, the others are PC-relative.
   always_comb begin
      kind   = redir_decode(redir_branch, redir_jal, redir_jalr);
      target = redir_pc + imm;
      if (kind == REDIR_JALR)
         target = (rs1 + imm) & ~XLEN'(1);
   end

   assign redir      = (kind != REDIR_NONE);
   assign target_bad = target[1];

   always_comb begin
      state_next = state;
      if (redir)
         state_next = target_bad ? FAULT : RUN;
   end

   // Queued entries plus outstanding requests never exceed the queue depth, so a response always has room.
   assign occupancy      = {1'b0, q_count} + {1'b0, in_flight};
   assign imem_req_valid = rst_n && (state == RUN) && (occupancy < DEPTH_LIM);
   assign imem_req_addr  = fetch_pc;
   assign req_hs         = imem_req_valid && imem_req_ready;
   assign in_flight_next = in_flight + CW'(req_hs) - CW'(imem_rsp_valid);
   assign rsp_push       = imem_rsp_valid && (drop_cnt == '0) && !redir && (tag_count != '0);
   assign q_empty        = (q_count == '0);
   assign q_pop          = inst_valid && inst_ready;
   assign fetch_fault    = (state == FAULT);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= RUN;
         fetch_pc   <= RESET_PC;
         in_flight  <= '0;
         drop_cnt   <= '0;
         fault_addr <= '0;
      end else begin
         state     <= state_next;
         in_flight <= in_flight_next;
         if (redir) begin
            drop_cnt <= in_flight_next;
            if (target_bad)
               fault_addr <= target;
            else
               fetch_pc <= target;
         end else begin
            if (imem_rsp_valid && (drop_cnt != '0))
               drop_cnt <= drop_cnt - CW'(1);
            if (req_hs)
               fetch_pc <= fetch_pc + XLEN'(INST_BYTES);
         end
      end
   end

   sync_fifo #(
      .WIDTH (XLEN),
      .DEPTH (FQ_DEPTH)
   ) u_tag_q (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (redir),
      .push      (req_hs && !redir),
      .push_data (fetch_pc),
      .pop       (rsp_push),
      .pop_data  (tag_pc),
      .count     (tag_count)
   );

   sync_fifo #(
      .WIDTH (XLEN + 32),
      .DEPTH (FQ_DEPTH)
   ) u_inst_q (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (redir),
      .push      (rsp_push),
      .push_data ({tag_pc, imem_rsp_data}),
      .pop       (q_pop),
      .pop_data  (q_head),
      .count     (q_count)
   );

   // Keeps the last presented head so decode sees stable data while the queue is empty.
   always_ff @(posedge clk) begin
      if (!rst_n)
         head_hold <= '0;
      else if (!q_empty)
         head_hold <= q_head;
   end

   assign inst_valid = !q_empty;
   assign inst_pc    = q_empty ? head_hold[XLEN+31:32] : q_head[XLEN+31:32];
   assign inst_data  = q_empty ? head_hold[31:0] : q_head[31:0];

endmodule

// File: tb/tb_ifetch_queue.sv
// Scoreboard bench for ifetch_queue: directed phases queue expected request addresses and instruction PCs,
// a memory model answers requests, and a monitor compares every request handshake and consumed instruction.
module tb_ifetch_queue;
   import ifetch_pkg::*;

   localparam logic [31:0] DATA_KEY = 32'hDEAD_0000;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        imem_req_valid;
   logic        imem_req_ready = 1'b0;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid = 1'b0;
   logic [31:0] imem_rsp_data = '0;
   logic        redir_branch = 1'b0;
   logic        redir_jal = 1'b0;
   logic        redir_jalr = 1'b0;
   logic [31:0] redir_pc = '0;
   logic [31:0] rs1 = '0;
   logic [31:0] imm = '0;
   logic        inst_valid;
   logic        inst_ready = 1'b0;
   logic [31:0] inst_data;
   logic [31:0] inst_pc;
   logic        fetch_fault;
   logic [31:0] fault_addr;

   int tests = 0;
   int failures = 0;
   int granted = 0;
   int used = 0;
   int lat = 1;
   int mcyc = 0;

   logic [31:0] req_exp[$];
   logic [31:0] pc_exp[$];
   logic [31:0] mem_addr[$];
   int          mem_due[$];

   ifetch_queue dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .redir_branch   (redir_branch),
      .redir_jal      (redir_jal),
      .redir_jalr     (redir_jalr),
      .redir_pc       (redir_pc),
      .rs1            (rs1),
      .imm            (imm),
      .inst_valid     (inst_valid),
      .inst_ready     (inst_ready),
      .inst_data      (inst_data),
      .inst_pc        (inst_pc),
      .fetch_fault    (fetch_fault),
      .fault_addr     (fault_addr)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic noteUnexpected(input string name, input logic [31:0] act);
      tests++;
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected nothing", name, act);
   endtask

   // Memory model: in-order responses a fixed latency after acceptance, accepting only granted requests.
   always begin
      @(negedge clk);
      #1;
      mcyc++;
      if (!rst_n) begin
         mem_addr.delete();
         mem_due.delete();
         imem_rsp_valid = 1'b0;
         imem_req_ready = 1'b0;
         used = 0;
      end else begin
         imem_req_ready = (used < granted);
         if (mem_due.size() > 0 && mem_due[0] <= mcyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_addr.pop_front() ^ DATA_KEY;
            void'(mem_due.pop_front());
         end else begin
            imem_rsp_valid = 1'b0;
         end
         #1;
         if (imem_req_valid && imem_req_ready) begin
            mem_addr.push_back(imem_req_addr);
            mem_due.push_back(mcyc + lat);
            used++;
         end
      end
   end

   // Monitor: compares request handshakes and consumed instructions against the scoreboard queues.
   always begin
      @(negedge clk);
      #3;
      if (rst_n && imem_req_valid && imem_req_ready) begin
         if (req_exp.size() == 0)
            noteUnexpected("req_addr", imem_req_addr);
         else
            checkOutput("req_addr", imem_req_addr, req_exp.pop_front());
      end
      if (inst_valid && inst_ready) begin
         if (pc_exp.size() == 0) begin
            noteUnexpected("inst_pc", inst_pc);
         end else begin
            logic [31:0] e;
            e = pc_exp.pop_front();
            checkOutput("inst_pc", inst_pc, e);
            checkOutput("inst_data", inst_data, e ^ DATA_KEY);
         end
      end
      if (rst_n && dut.u_inst_q.push && dut.u_inst_q.full && !dut.u_inst_q.pop)
         noteUnexpected("push_while_full", inst_pc);
   end

   task automatic nextCycle();
      @(negedge clk);
      redir_branch = 1'b0;
      redir_jal    = 1'b0;
      redir_jalr   = 1'b0;
      #3;
   endtask

   task automatic applyStimulus(input redir_kind_t kind, input logic [31:0] pc,
                                input logic [31:0] base, input logic [31:0] offs);
      @(negedge clk);
      redir_branch = (kind == REDIR_BRANCH);
      redir_jal    = (kind == REDIR_JAL);
      redir_jalr   = (kind == REDIR_JALR);
      redir_pc     = pc;
      rs1          = base;
      imm          = offs;
      #3;
   endtask

   task automatic assertReset();
      @(negedge clk);
      rst_n   = 1'b0;
      granted = 0;
      #3;
      nextCycle();
      nextCycle();
      req_exp.delete();
      pc_exp.delete();
   endtask

   task automatic releaseReset();
      @(negedge clk);
      rst_n = 1'b1;
      #3;
   endtask

   task automatic expectSeq(input logic [31:0] start, input int n, input bit to_req, input bit to_pc);
      for (int i = 0; i < n; i++) begin
         if (to_req)
            req_exp.push_back(start + 32'(4 * i));
         if (to_pc)
            pc_exp.push_back(start + 32'(4 * i));
      end
   endtask

   task automatic checkReset(input string tag);
      checkOutput({tag, "_req_valid"}, 32'(imem_req_valid), 32'h0);
      checkOutput({tag, "_req_addr"}, imem_req_addr, 32'h0);
      checkOutput({tag, "_inst_valid"}, 32'(inst_valid), 32'h0);
      checkOutput({tag, "_inst_data"}, inst_data, 32'h0);
      checkOutput({tag, "_inst_pc"}, inst_pc, 32'h0);
      checkOutput({tag, "_fetch_fault"}, 32'(fetch_fault), 32'h0);
      checkOutput({tag, "_fault_addr"}, fault_addr, 32'h0);
   endtask

   task automatic checkDrained(input string tag);
      checkOutput({tag, "_req_left"}, 32'(req_exp.size()), 32'h0);
      checkOutput({tag, "_inst_left"}, 32'(pc_exp.size()), 32'h0);
   endtask

   initial begin
      // Reset values, then a streaming fetch with single-cycle memory latency.
      repeat (3) nextCycle();
      checkReset("rst");
      lat        = 1;
      inst_ready = 1'b1;
      granted    = 5;
      expectSeq(32'h0, 5, 1'b1, 1'b1);
      releaseReset();
      checkOutput("first_req_valid", 32'(imem_req_valid), 32'h1);
      checkOutput("first_req_addr", imem_req_addr, 32'h0);
      checkOutput("inst_valid_c0", 32'(inst_valid), 32'h0);
      nextCycle();
      checkOutput("inst_valid_c1", 32'(inst_valid), 32'h0);
      nextCycle();
      checkOutput("inst_valid_c2", 32'(inst_valid), 32'h1);
      checkOutput("first_inst_pc", inst_pc, 32'h0);
      repeat (12) nextCycle();
      checkDrained("stream");

      // Decode stalled: credits cap issue at four, then fetch resumes at 0x10.
      assertReset();
      inst_ready = 1'b0;
      granted    = 8;
      expectSeq(32'h0, 4, 1'b1, 1'b1);
      releaseReset();
      repeat (10) nextCycle();
      checkOutput("full_req_valid", 32'(imem_req_valid), 32'h0);
      checkOutput("full_req_count", 32'(used), 32'h4);
      checkOutput("full_inst_valid", 32'(inst_valid), 32'h1);
      checkOutput("full_head_pc", inst_pc, 32'h0);
      expectSeq(32'h10, 4, 1'b1, 1'b1);
      @(negedge clk);
      inst_ready = 1'b1;
      #3;
      repeat (15) nextCycle();
      checkDrained("stall");

      // jal with three requests outstanding: stale responses must all be dropped.
      assertReset();
      lat     = 10;
      granted = 3;
      expectSeq(32'h0, 3, 1'b1, 1'b0);
      releaseReset();
      repeat (4) nextCycle();
      expectSeq(32'h120, 2, 1'b1, 1'b1);
      applyStimulus(REDIR_JAL, 32'h100, 32'h0, 32'h20);
      granted += 2;
      nextCycle();
      checkOutput("jal_req_valid", 32'(imem_req_valid), 32'h1);
      checkOutput("jal_req_addr", imem_req_addr, 32'h120);
      checkOutput("jal_inst_valid", 32'(inst_valid), 32'h0);
      repeat (20) nextCycle();
      checkDrained("jal");

      // jalr clears bit 0 of rs1+imm.
      lat = 1;
      expectSeq(32'h2004, 3, 1'b1, 1'b1);
      applyStimulus(REDIR_JALR, 32'h0, 32'h2001, 32'h4);
      granted += 3;
      nextCycle();
      checkOutput("jalr_req_addr", imem_req_addr, 32'h2004);
      repeat (10) nextCycle();
      checkDrained("jalr");

      // Misaligned branch target faults; a second bad target updates fault_addr; jal recovers.
      applyStimulus(REDIR_BRANCH, 32'h40, 32'h0, 32'h2);
      nextCycle();
      granted += 5;
      checkOutput("fault_flag", 32'(fetch_fault), 32'h1);
      checkOutput("fault_addr", fault_addr, 32'h42);
      checkOutput("fault_req_valid", 32'(imem_req_valid), 32'h0);
      checkOutput("fault_inst_valid", 32'(inst_valid), 32'h0);
      repeat (4) nextCycle();
      checkOutput("fault_idle_req_valid", 32'(imem_req_valid), 32'h0);
      applyStimulus(REDIR_BRANCH, 32'h40, 32'h0, 32'h6);
      nextCycle();
      checkOutput("fault_addr_update", fault_addr, 32'h46);
      checkOutput("fault_flag_held", 32'(fetch_fault), 32'h1);
      expectSeq(32'h80, 5, 1'b1, 1'b1);
      applyStimulus(REDIR_JAL, 32'h60, 32'h0, 32'h20);
      nextCycle();
      checkOutput("recover_fault_flag", 32'(fetch_fault), 32'h0);
      checkOutput("recover_req_valid", 32'(imem_req_valid), 32'h1);
      checkOutput("recover_req_addr", imem_req_addr, 32'h80);
      repeat (10) nextCycle();
      checkDrained("recover");

      // Redirect coinciding with a request handshake and a response.
      assertReset();
      lat     = 2;
      granted = 3;
      expectSeq(32'h0, 3, 1'b1, 1'b0);
      expectSeq(32'h210, 2, 1'b1, 1'b1);
      releaseReset();
      nextCycle();
      applyStimulus(REDIR_JAL, 32'h200, 32'h0, 32'h10);
      checkOutput("simul_hs_in_redirect", 32'(imem_req_valid && imem_req_ready), 32'h1);
      granted += 2;
      nextCycle();
      checkOutput("simul_inst_valid", 32'(inst_valid), 32'h0);
      checkOutput("simul_req_addr", imem_req_addr, 32'h210);
      repeat (10) nextCycle();
      checkDrained("simul");

      // Reset in the middle of a burst returns every output to its reset value.
      assertReset();
      lat     = 1;
      granted = 6;
      expectSeq(32'h0, 6, 1'b1, 1'b1);
      releaseReset();
      repeat (4) nextCycle();
      @(negedge clk);
      rst_n   = 1'b0;
      granted = 0;
      #3;
      nextCycle();
      checkReset("midrst");
      req_exp.delete();
      pc_exp.delete();

      $display("[TB] %0d tests run, %0d failed", tests, failures);
      $finish;
   end

endmodule
